rom_port_arbiter: RTL and testbench

Sequential two-requester arbiter that shares the single combinational instruction ROM read port between the CPU instruction-fetch stage and the load/store unit, which needs ROM reads for constant-table loads.
- Grants at most one access per cycle and drives the ROM address.
- Registers the returned word and delivers it with a one-cycle valid pulse to the winning requester.
- Flags misaligned or out-of-range addresses instead of returning ROM default contents.
- Sits between the fetch/LSU and the ROM in the single-cycle/pipelined CPU top level.

---
 rtl/rom_arb_pkg.sv | 15 +
 rtl/rom_port_arbiter_if.sv | 32 +++
 rtl/rom_port_arbiter.sv | 87 ++++++++
 tb/tb_rom_port_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the ROM read-port arbiter.
// Covers the priority state, the default starvation limit, error data and ROM index width.
package rom_arb_pkg;

    typedef enum logic {
        PRIO_LS = 1'b0,
        PRIO_IF = 1'b1
    } prio_t;

    localparam int          STARVE_MAX_DEF = 4;
    localparam logic [31:0] ERR_DATA       = 32'h0000_0000;
    localparam int          ROM_IDX_W      = 6;
    localparam int          ROM_WORDS_DEF  = 1 << ROM_IDX_W;

endpackage

// File: rtl/rom_port_arbiter_if.sv
// Fetch, load/store and ROM-side signals of the shared instruction ROM read port.
// The arbiter takes the slave side; the fetch/LSU/ROM environment takes the master side.
interface rom_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;

    logic        ls_req;
    logic [31:0] ls_addr;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        ls_err;

    logic [31:0] rom_addr;
    logic [31:0] rom_data;

    modport slave (
        input  if_req, if_addr, ls_req, ls_addr, rom_data,
        output if_gnt, if_rvalid, if_rdata, if_err,
        output ls_gnt, ls_rvalid, ls_rdata, ls_err, rom_addr
    );

    modport master (
        output if_req, if_addr, ls_req, ls_addr, rom_data,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        input  ls_gnt, ls_rvalid, ls_rdata, ls_err, rom_addr
    );
endinterface

// File: rtl/rom_port_arbiter.sv
// Shares the combinational instruction ROM read port between instruction fetch and the LSU.
// One access per cycle; the response is registered and returned one cycle later.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   PRIO_LS | load/store wins a conflict (reset state)
//   PRIO_IF | fetch wins a conflict, until fetch is granted
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ROM_WORDS  = ROM_WORDS_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    rom_port_arbiter_if.slave  bus
);

    localparam int              SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]   STARVE_TOP = SW'(STARVE_MAX);
    localparam logic [31:0]     ADDR_LIMIT = 32'(ROM_WORDS * 4);

    prio_t          prio;
    logic [SW-1:0]  starve;
    logic [SW-1:0]  starve_nxt;
    logic           owner;
    logic           rvalid_q;
    logic           err_q;
    logic [31:0]    data_q;

    logic           if_win;
    logic           ls_win;
    logic           any_gnt;
    logic           acc_err;
    logic [31:0]    acc_addr;

    // Grants are gated by reset_n so nothing is accepted while reset is held.
    always_comb begin
        if_win     = reset_n & bus.if_req & (~bus.ls_req | (prio == PRIO_IF));
        ls_win     = reset_n & bus.ls_req & (~bus.if_req | (prio == PRIO_LS));
        any_gnt    = if_win | ls_win;
        acc_addr   = if_win ? bus.if_addr : (ls_win ? bus.ls_addr : 32'h0);
        acc_err    = (acc_addr[1:0] != 2'b00) | (acc_addr >= ADDR_LIMIT);
        starve_nxt = starve;
        if (if_win) begin
            starve_nxt = '0;
        end else if (bus.if_req && (starve != STARVE_TOP)) begin
            starve_nxt = starve + 1'b1;
        end
    end

    assign bus.if_gnt    = if_win;
    assign bus.ls_gnt    = ls_win;
    assign bus.rom_addr  = acc_addr;
    assign bus.if_rvalid = rvalid_q & ~owner;
    assign bus.ls_rvalid = rvalid_q & owner;
    assign bus.if_rdata  = data_q;
    assign bus.ls_rdata  = data_q;
    assign bus.if_err    = err_q;
    assign bus.ls_err    = err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio     <= PRIO_LS;
            starve   <= '0;
            owner    <= 1'b0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            data_q   <= 32'h0;
        end else begin
            rvalid_q <= any_gnt;
            starve   <= starve_nxt;
            if (any_gnt) begin
                owner  <= ls_win;
                err_q  <= acc_err;
                data_q <= acc_err ? ERR_DATA : bus.rom_data;
            end
            // Priority flips in the same edge the counter saturates, so the very next conflict goes to fetch.
            case (prio)
                PRIO_LS: if (starve_nxt == STARVE_TOP) prio <= PRIO_IF;
                PRIO_IF: if (if_win) prio <= PRIO_LS;
                default: prio <= PRIO_LS;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter: a small combinational ROM model and
// hand-computed expected grants, responses and starvation counts.
module tb_rom_port_arbiter;
    import rom_arb_pkg::*;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    rom_port_arbiter_if bus ();

    rom_port_arbiter #(.ROM_WORDS(64), .STARVE_MAX(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: words 0..2 fixed, others 0xA500_00xx with the word index.
    always_comb begin
        logic [5:0] idx;
        idx = bus.rom_addr[7:2];
        case (idx)
            6'd0:    bus.rom_data = 32'h0800_0003;
            6'd1:    bus.rom_data = 32'h0800_0032;
            6'd2:    bus.rom_data = 32'h0800_0077;
            default: bus.rom_data = 32'hA500_0000 | {26'h0, idx};
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0;
        bus.ls_req  = 1'b1;
        bus.ls_addr = 32'h4;

        // Reset state, with requests held high
        #2;
        chk("rst_if_gnt",    32'(bus.if_gnt), 0);
        chk("rst_ls_gnt",    32'(bus.ls_gnt), 0);
        chk("rst_rom_addr",  bus.rom_addr, 0);
        chk("rst_if_rvalid", 32'(bus.if_rvalid), 0);
        chk("rst_ls_rvalid", 32'(bus.ls_rvalid), 0);
        chk("rst_rdata",     bus.if_rdata, 0);
        chk("rst_err",       32'(bus.if_err), 0);
        chk("rst_starve",    32'(dut.starve), 0);
        tick();
        chk("rst_held_rvalid", 32'(bus.if_rvalid | bus.ls_rvalid), 0);
        bus.if_req = 1'b0;
        bus.ls_req = 1'b0;
        reset_n    = 1'b1;
        tick();

        // Fetch only, back-to-back 0x0, 0x4, 0x8
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0;
        #1 chk("seq_gnt0", 32'(bus.if_gnt), 1);
        chk("seq_rom_addr0", bus.rom_addr, 32'h0);
        tick();
        chk("seq_rvalid0", 32'(bus.if_rvalid), 1);
        chk("seq_rdata0",  bus.if_rdata, 32'h0800_0003);
        bus.if_addr = 32'h4;
        #1 chk("seq_gnt1", 32'(bus.if_gnt), 1);
        tick();
        chk("seq_rvalid1", 32'(bus.if_rvalid), 1);
        chk("seq_rdata1",  bus.if_rdata, 32'h0800_0032);
        chk("seq_ls_rvalid1", 32'(bus.ls_rvalid), 0);
        bus.if_addr = 32'h8;
        #1 chk("seq_gnt2", 32'(bus.if_gnt), 1);
        tick();
        chk("seq_rvalid2", 32'(bus.if_rvalid), 1);
        chk("seq_rdata2",  bus.if_rdata, 32'h0800_0077);
        chk("seq_ls_rvalid2", 32'(bus.ls_rvalid), 0);
        bus.if_req = 1'b0;
        tick();
        chk("seq_rvalid_end", 32'(bus.if_rvalid), 0);

        // Conflict with starvation: ls wins 4 times, then if, then ls again
        bus.if_req  = 1'b1;
        bus.if_addr = 32'hC;
        bus.ls_req  = 1'b1;
        bus.ls_addr = 32'h10;
        for (int i = 1; i <= 4; i++) begin
            #1 chk("stv_ls_gnt", 32'(bus.ls_gnt), 1);
            chk("stv_if_gnt", 32'(bus.if_gnt), 0);
            tick();
            chk("stv_count", 32'(dut.starve), 32'(i));
            chk("stv_ls_rvalid", 32'(bus.ls_rvalid), 1);
            chk("stv_ls_rdata", bus.ls_rdata, 32'hA500_0004);
        end
        #1 chk("stv5_if_gnt", 32'(bus.if_gnt), 1);
        chk("stv5_ls_gnt", 32'(bus.ls_gnt), 0);
        chk("stv5_rom_addr", bus.rom_addr, 32'hC);
        tick();
        chk("stv5_starve", 32'(dut.starve), 0);
        chk("stv5_if_rvalid", 32'(bus.if_rvalid), 1);
        chk("stv5_ls_rvalid", 32'(bus.ls_rvalid), 0);
        chk("stv5_if_rdata", bus.if_rdata, 32'hA500_0003);
        #1 chk("stv6_ls_gnt", 32'(bus.ls_gnt), 1);
        chk("stv6_if_gnt", 32'(bus.if_gnt), 0);
        bus.if_req = 1'b0;
        #1 chk("stv6_ls_gnt_solo", 32'(bus.ls_gnt), 1);
        tick();
        chk("stv6_ls_rvalid", 32'(bus.ls_rvalid), 1);
        bus.ls_req = 1'b0;
        tick();

        // Misaligned ls access
        bus.ls_req  = 1'b1;
        bus.ls_addr = 32'h6;
        #1 chk("mis_ls_gnt", 32'(bus.ls_gnt), 1);
        tick();
        bus.ls_req = 1'b0;
        chk("mis_ls_rvalid", 32'(bus.ls_rvalid), 1);
        chk("mis_ls_err",    32'(bus.ls_err), 1);
        chk("mis_ls_rdata",  bus.ls_rdata, 32'h0);
        chk("mis_if_rvalid", 32'(bus.if_rvalid), 0);
        tick();

        // Out-of-range fetch, then a good one
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        #1 chk("oor_if_gnt", 32'(bus.if_gnt), 1);
        tick();
        chk("oor_if_rvalid", 32'(bus.if_rvalid), 1);
        chk("oor_if_err",    32'(bus.if_err), 1);
        chk("oor_if_rdata",  bus.if_rdata, 32'h0);
        bus.if_addr = 32'h0;
        tick();
        chk("oor_ok_rvalid", 32'(bus.if_rvalid), 1);
        chk("oor_ok_err",    32'(bus.if_err), 0);
        chk("oor_ok_rdata",  bus.if_rdata, 32'h0800_0003);
        bus.if_req = 1'b0;
        tick();

        // Reset asserted after grant, before the capturing edge
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0;
        #1 chk("rr_if_gnt", 32'(bus.if_gnt), 1);
        #1 reset_n = 1'b0;
        #1 chk("rr_gnt_in_rst", 32'(bus.if_gnt), 0);
        chk("rr_rom_addr", bus.rom_addr, 0);
        tick();
        chk("rr_if_rvalid", 32'(bus.if_rvalid), 0);
        chk("rr_rdata",     bus.if_rdata, 0);
        chk("rr_err",       32'(bus.if_err), 0);
        chk("rr_starve",    32'(dut.starve), 0);
        tick();
        chk("rr_if_rvalid2", 32'(bus.if_rvalid), 0);
        reset_n = 1'b1;
        #1 chk("rr_regnt", 32'(bus.if_gnt), 1);
        tick();
        chk("rr_done_rvalid", 32'(bus.if_rvalid), 1);
        chk("rr_done_rdata",  bus.if_rdata, 32'h0800_0003);
        bus.if_req = 1'b0;
        tick();

        // ls request withdrawn in the cycle fetch arrives
        bus.ls_req  = 1'b1;
        bus.ls_addr = 32'h8;
        #1 bus.ls_req = 1'b0;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h8;
        #1 chk("wd_if_gnt", 32'(bus.if_gnt), 1);
        chk("wd_ls_gnt",   32'(bus.ls_gnt), 0);
        chk("wd_rom_addr", bus.rom_addr, 32'h8);
        tick();
        bus.if_req = 1'b0;
        chk("wd_if_rvalid", 32'(bus.if_rvalid), 1);
        chk("wd_if_rdata",  bus.if_rdata, 32'h0800_0077);
        chk("wd_ls_rvalid", 32'(bus.ls_rvalid), 0);
        tick();
        chk("wd_ls_rvalid2", 32'(bus.ls_rvalid), 0);
        chk("wd_if_rvalid2", 32'(bus.if_rvalid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
